piso_shift_param: RTL and testbench
===================================

// Module: piso_shift_param
// PURPOSE
//  Parametrised parallel-in/serial-out shifter with a valid/ready load handshake,
//  selectable bit order, stall control, and word framing (busy/last).
//  Serialises WIDTH-bit words onto a single output line for serial TX paths.
//  Sits between a word producer (FIFO or FSM) and a bit-serial consumer.
//  Supports back-to-back words with no idle gap.
// PARAMETERS
//  WIDTH       8   word width in bits; legal range 2..32
//  MSB_FIRST   1   1: bit WIDTH-1 shifted out first; 0: bit 0 shifted out first
//  IDLE_LEVEL  0   value driven on so while not busy
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  load_valid  in   1      producer has a word on pi
//  load_ready  out  1      shifter can accept a word this cycle
//  pi          in   WIDTH  parallel word, sampled on accept
//  shift_en    in   1      1: advance one bit this cycle; 0: hold (stall)
//  so          out  1      serial data out
//  so_valid    out  1      so carries a data bit (equals busy)
//  busy        out  1      word in flight
//  last        out  1      so is the final bit of the current word
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, shift reg=0, cnt=0.
//    Outputs: so=IDLE_LEVEL, so_valid=0, busy=0, last=0, load_ready=1.
//  - Registers: state {IDLE, SHIFT}; q[WIDTH-1:0]; cnt[$clog2(WIDTH)-1:0].
//  - Accept = load_valid & load_ready, sampled at the rising edge.
//  - load_ready = (state==IDLE) | (state==SHIFT & last & shift_en). Combinational.
//  - IDLE:
//    - On accept: q<=pi, cnt<=0, go to SHIFT.
//    - Otherwise hold; pi is ignored.
//  - SHIFT:
//    - so = MSB_FIRST ? q[WIDTH-1] : q[0] (combinational from q).
//    - so_valid = busy = 1.
//    - last = (cnt==WIDTH-1).
//    - shift_en=0: q, cnt and state hold; so stays stable (stall, any length).
//    - shift_en=1 & !last: q shifts toward the output end with 0 fill, cnt<=cnt+1.
//    - shift_en=1 & last & accept: q<=pi, cnt<=0, stay in SHIFT (back-to-back).
//    - shift_en=1 & last & !accept: go to IDLE, q<=0.
//  - Latency: the first bit appears on so the cycle after accept.
//  - A word occupies exactly WIDTH cycles with shift_en=1.
//  - load_valid while busy and not (last & shift_en): not accepted; the producer holds pi.
//  - Reset mid-word: the word is discarded immediately (async); no partial bits follow.
//  - WIDTH not a power of 2: cnt still compares against WIDTH-1; no wrap occurs past it.
// TESTING
//  1. Assert rst mid-run -> so=IDLE_LEVEL, busy=0, load_ready=1 with no clock edge.
//  2. WIDTH=8, MSB_FIRST=1, accept 8'hA5, shift_en=1 -> so=1,0,1,0,0,1,0,1.
//     last high on the 8th bit only; then IDLE.
//  3. MSB_FIRST=0, accept 8'hA5 -> so=1,0,1,0,0,1,0,1 (LSB first).
//     Check with 8'h01 -> 1,0,0,0,0,0,0,0.
//  4. Drop shift_en for 3 cycles after bit 2 of 8'hC3.
//     -> so and cnt frozen; the stream resumes intact for 8 data bits total.
//  5. Back-to-back: 8'hFF then 8'h00 with load_valid held.
//     -> 16 consecutive so_valid cycles; load_ready pulses only with last.
//  6. load_valid asserted mid-word (bit 4) with 8'h3C -> not accepted until last.
//     The current word completes unaltered.

Source files
------------

// File: rtl/piso_shift_param.sv
// piso_shift_param: parallel-in/serial-out shifter with valid/ready load, bit order select, stall and busy/last framing
module piso_shift_param #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pi,
   input  logic             shift_en,
   output logic             so,
   output logic             so_valid,
   output logic             busy,
   output logic             last
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt, w_shifted;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             w_accept;
   assign busy       = r_state == SHIFT;
   assign so_valid   = busy;
   assign last       = busy & (r_cnt == CW'(WIDTH - 1));
   assign load_ready = !busy | (last & shift_en);
   assign w_accept   = load_valid & load_ready;
   assign so         = busy ? (MSB_FIRST ? r_q[WIDTH-1] : r_q[0]) : IDLE_LEVEL;
   assign w_shifted  = MSB_FIRST ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
   // an accept either starts a word from idle or chains onto the last bit of the current one
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      if (w_accept) begin
         w_state_nxt = SHIFT;
         w_q_nxt     = pi;
         w_cnt_nxt   = '0;
      end else if (busy && shift_en) begin
         w_state_nxt = last ? IDLE : SHIFT;
         w_q_nxt     = last ? '0 : w_shifted;
         w_cnt_nxt   = last ? '0 : r_cnt + CW'(1);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
endmodule

// File: tb/tb_piso_shift_param.sv
// tb_piso_shift_param: directed vectors against an MSB-first/idle-0 and an LSB-first/idle-1 instance sharing stimulus
module tb_piso_shift_param;
   typedef struct {
      logic       lv;
      logic [7:0] pi;
      logic       se;
      logic       so_m;
      logic       so_l;
      logic       bz;
      logic       ls;
      logic       rd;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, lv = 1'b0, se = 1'b0;
   logic [7:0] pi = 8'h00;
   logic rdy_m, so_m, sov_m, busy_m, last_m;
   logic rdy_l, so_l, sov_l, busy_l, last_l;
   int checks = 0, errors = 0, cyc = 0;
   vec_t tbl[$];
   always #5 clk = ~clk;
   piso_shift_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
      .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy_m), .pi(pi), .shift_en(se),
      .so(so_m), .so_valid(sov_m), .busy(busy_m), .last(last_m));
   piso_shift_param #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
      .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy_l), .pi(pi), .shift_en(se),
      .so(so_l), .so_valid(sov_l), .busy(busy_l), .last(last_l));
   task automatic cmp(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask
   task automatic chk_outs(input logic som, input logic sol, input logic bz, input logic ls, input logic rd);
      cmp("so_msb", so_m, som);
      cmp("so_lsb", so_l, sol);
      cmp("busy_msb", busy_m, bz);
      cmp("busy_lsb", busy_l, bz);
      cmp("so_valid_msb", sov_m, bz);
      cmp("so_valid_lsb", sov_l, bz);
      cmp("last_msb", last_m, ls);
      cmp("last_lsb", last_l, ls);
      cmp("ready_msb", rdy_m, rd);
      cmp("ready_lsb", rdy_l, rd);
   endtask
   // drive one cycle's inputs at the falling edge, then check the combinational outputs before the next rising edge
   task automatic step(input logic lv_i, input logic [7:0] pi_i, input logic se_i,
                       input logic som, input logic sol, input logic bz, input logic ls, input logic rd);
      @(negedge clk);
      lv = lv_i;
      pi = pi_i;
      se = se_i;
      #1;
      chk_outs(som, sol, bz, ls, rd);
      cyc++;
   endtask
   function automatic void v(input logic lv_i, input logic [7:0] pi_i, input logic se_i,
                             input logic som, input logic sol, input logic bz, input logic ls, input logic rd);
      tbl.push_back('{lv_i, pi_i, se_i, som, sol, bz, ls, rd});
   endfunction
   // sm/sl list the expected serial bits in emission order, first bit in position 7
   function automatic void vword(input logic [7:0] sm, input logic [7:0] sl, input logic lv_i, input logic [7:0] pi_i);
      for (int i = 0; i < 8; i++) v(lv_i, pi_i, 1'b1, sm[7-i], sl[7-i], 1'b1, i == 7, i == 7);
   endfunction
   initial begin
      v(1, 8'hA5, 1, 0, 1, 0, 0, 1);
      vword(8'b10100101, 8'b10100101, 0, 8'h00);
      v(0, 8'h00, 1, 0, 1, 0, 0, 1);
      v(1, 8'h01, 1, 0, 1, 0, 0, 1);
      vword(8'b00000001, 8'b10000000, 0, 8'h00);
      v(0, 8'h00, 1, 0, 1, 0, 0, 1);
      v(1, 8'hFF, 1, 0, 1, 0, 0, 1);
      vword(8'hFF, 8'hFF, 1, 8'h00);
      vword(8'h00, 8'h00, 0, 8'h00);
      v(0, 8'h00, 1, 0, 1, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1, 0, 0, 1);
      #1 rst = 1'b0;
      foreach (tbl[k]) step(tbl[k].lv, tbl[k].pi, tbl[k].se, tbl[k].so_m, tbl[k].so_l, tbl[k].bz, tbl[k].ls, tbl[k].rd);
      // stall for 3 cycles while bit 2 of C3 is on the line
      step(1, 8'hC3, 1, 0, 1, 0, 0, 1);
      step(0, 8'h00, 1, 1, 1, 1, 0, 0);
      step(0, 8'h00, 1, 1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0, 1, 0, 0);
      begin
         logic [7:0] c3 = 8'b11000011;
         for (int i = 2; i < 8; i++) step(0, 8'h00, 1, c3[7-i], c3[7-i], 1, i == 7, i == 7);
      end
      step(0, 8'h00, 1, 0, 1, 0, 0, 1);
      // 3C offered from bit 4 of A5; refused until last, including a stalled last bit
      step(1, 8'hA5, 1, 0, 1, 0, 0, 1);
      begin
         logic [7:0] a5 = 8'b10100101;
         logic [7:0] s3c = 8'b00111100;
         for (int i = 0; i < 4; i++) step(0, 8'h00, 1, a5[7-i], a5[7-i], 1, 0, 0);
         for (int i = 4; i < 7; i++) step(1, 8'h3C, 1, a5[7-i], a5[7-i], 1, 0, 0);
         step(1, 8'h3C, 0, 1, 1, 1, 1, 0);
         step(1, 8'h3C, 1, 1, 1, 1, 1, 1);
         for (int i = 0; i < 8; i++) step(0, 8'h00, 1, s3c[7-i], s3c[7-i], 1, i == 7, i == 7);
      end
      step(0, 8'h00, 1, 0, 1, 0, 0, 1);
      // asynchronous reset in the middle of a word
      step(1, 8'hFF, 1, 0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 1, 1, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_outs(0, 1, 0, 0, 1);
      cyc++;
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 1, 0, 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
